// File: rtl/mtm_alu_frame_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mtm_alu_frame_tx_if                                                        |
// | Stimulus-side bundle of the ALU serial frame transmitter.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mtm_alu_frame_tx_if;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  op;
   logic [3:0]  n_data;
   logic        crc_bad;
   logic        sin;
   logic        ready;
   logic        done;
   logic [15:0] frame_cnt;

   modport master (
      output start, A, B, op, n_data, crc_bad,
      input  sin, ready, done, frame_cnt
   );

   modport slave (
      input  start, A, B, op, n_data, crc_bad,
      output sin, ready, done, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/mtm_alu_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mtm_alu_frame_tx                                                           |
// | Serialises {B,A} data packets and a CTL packet (op + CRC-4) onto sin.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mtm_alu_frame_tx #(
   parameter int GAP = 0,
   parameter int IFG = 2
) (
   input  logic              clk,
   input  logic              reset,
   mtm_alu_frame_tx_if.slave bus
);

   localparam int c_idle_max  = (GAP > IFG) ? GAP : IFG;
   localparam int c_idle_w    = (c_idle_max > 2) ? $clog2(c_idle_max) : 1;
   localparam int c_gap_last  = (GAP > 0) ? GAP - 1 : 0;
   localparam int c_tail_last = (IFG > 1) ? IFG - 2 : 0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DATA = 3'd1,
      S_PGAP = 3'd2,
      S_CTL  = 3'd3,
      S_TAIL = 3'd4
   } state_t;

   state_t              r_state;
   logic [9:0]          r_shift;
   logic [3:0]          r_bit_cnt;
   logic [3:0]          r_pkt_cnt;
   logic [3:0]          r_n_data;
   logic [63:0]         r_payload;
   logic [7:0]          r_ctl_byte;
   logic [9:0]          r_pend_pkt;
   logic                r_pend_ctl;
   logic [c_idle_w-1:0] r_idle_cnt;
   logic                r_sin;
   logic                r_ready;
   logic                r_done;
   logic [15:0]         r_frame_cnt;

   logic [3:0]          w_next_idx;
   logic                w_next_is_ctl;
   logic [7:0]          w_next_byte;
   logic [9:0]          w_next_pkt;
   logic [3:0]          w_accept_crc;
   logic [7:0]          w_accept_ctl;

   // Bit-serial CRC-4, x^4+x+1, init 0, MSB first.
   function automatic logic [3:0] crc4(input logic [67:0] v);
      logic [3:0] c;
      logic       fb;
      c = 4'd0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ v[i];
         c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return c;
   endfunction

   // Everything after the start bit: flag, data MSB first, stop.
   function automatic logic [9:0] pkt_body(input logic flag, input logic [7:0] d);
      return {flag, d, 1'b1};
   endfunction

   assign w_next_idx    = r_pkt_cnt + 4'd1;
   assign w_next_is_ctl = (w_next_idx == r_n_data);
   assign w_next_byte   = w_next_idx[3] ? 8'h00
                        : r_payload[{3'd7 - w_next_idx[2:0], 3'b000} +: 8];
   assign w_next_pkt    = w_next_is_ctl ? pkt_body(1'b1, r_ctl_byte)
                                        : pkt_body(1'b0, w_next_byte);

   assign w_accept_crc  = crc4({bus.B, bus.A, 1'b1, bus.op}) ^ {4{bus.crc_bad}};
   assign w_accept_ctl  = {1'b0, bus.op, w_accept_crc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shift     <= 10'h3FF;
         r_bit_cnt   <= 4'd0;
         r_pkt_cnt   <= 4'd0;
         r_n_data    <= 4'd0;
         r_payload   <= 64'd0;
         r_ctl_byte  <= 8'd0;
         r_pend_pkt  <= 10'h3FF;
         r_pend_ctl  <= 1'b0;
         r_idle_cnt  <= '0;
         r_sin       <= 1'b1;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sin <= 1'b1;
               if (bus.start && r_ready) begin
                  r_payload  <= {bus.B, bus.A};
                  r_ctl_byte <= w_accept_ctl;
                  r_n_data   <= bus.n_data;
                  r_pkt_cnt  <= 4'd0;
                  r_ready    <= 1'b0;
                  r_sin      <= 1'b0;
                  r_bit_cnt  <= 4'd0;
                  if (bus.n_data == 4'd0) begin
                     r_shift <= pkt_body(1'b1, w_accept_ctl);
                     r_state <= S_CTL;
                  end else begin
                     r_shift <= pkt_body(1'b0, bus.B[31:24]);
                     r_state <= S_DATA;
                  end
               end
            end

            S_DATA, S_CTL: begin
               if (r_bit_cnt != 4'd10) begin
                  r_sin     <= r_shift[9];
                  r_shift   <= {r_shift[8:0], 1'b1};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_state == S_CTL && r_bit_cnt == 4'd9) begin
                     r_done      <= 1'b1;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end
               end else if (r_state == S_DATA) begin
                  r_pkt_cnt <= w_next_idx;
                  if (GAP > 0) begin
                     r_sin      <= 1'b1;
                     r_pend_pkt <= w_next_pkt;
                     r_pend_ctl <= w_next_is_ctl;
                     r_idle_cnt <= '0;
                     r_state    <= S_PGAP;
                  end else begin
                     r_sin     <= 1'b0;
                     r_shift   <= w_next_pkt;
                     r_bit_cnt <= 4'd0;
                     r_state   <= w_next_is_ctl ? S_CTL : S_DATA;
                  end
               end else begin
                  // The IDLE cycle that accepts the next start is itself the
                  // last inter-frame idle cycle, so TAIL holds IFG-1 cycles.
                  r_sin <= 1'b1;
                  if (IFG > 1) begin
                     r_idle_cnt <= '0;
                     r_state    <= S_TAIL;
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end

            S_PGAP: begin
               if (r_idle_cnt == c_idle_w'(c_gap_last)) begin
                  r_sin     <= 1'b0;
                  r_shift   <= r_pend_pkt;
                  r_bit_cnt <= 4'd0;
                  r_state   <= r_pend_ctl ? S_CTL : S_DATA;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end

            S_TAIL: begin
               r_sin <= 1'b1;
               if (r_idle_cnt == c_idle_w'(c_tail_last)) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end

            default: begin
               r_sin   <= 1'b1;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.sin       = r_sin;
   assign bus.ready     = r_ready;
   assign bus.done      = r_done;
   assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mtm_alu_frame_tx                                                        |
// | Scoreboard bench: expected packets queued at accept, decoded from sin.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mtm_alu_frame_tx;

   localparam int GAP1 = 2;
   localparam int IFG  = 2;

   typedef struct packed {
      logic [10:0] bits;
      logic [7:0]  gap;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   vectors;
   int   miscompares;

   exp_t        exp_q[2][$];
   bit          mon_busy[2];
   logic [10:0] mon_bits[2];
   int          mon_cnt[2];
   int          mon_idle[2];
   int          mon_gap[2];
   logic [63:0] last_word[2];
   logic [7:0]  last_ctl[2];

   mtm_alu_frame_tx_if bus0 ();
   mtm_alu_frame_tx_if bus1 ();

   mtm_alu_frame_tx #(.GAP(0), .IFG(IFG)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   mtm_alu_frame_tx #(.GAP(GAP1), .IFG(IFG)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
      vectors++;
      assert (obsv === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
      end
   endtask

   // Reference CRC by polynomial long division of {B,A,1,op,0000} by 10011.
   function automatic logic [3:0] crc_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      logic [71:0] v;
      v = {b, a, 1'b1, op, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
      return v[3:0];
   endfunction

   task automatic mon(input int d, input logic s, input logic dn);
      exp_t e;
      if (!mon_busy[d]) begin
         if (s === 1'b0) begin
            mon_busy[d] = 1'b1;
            mon_bits[d] = 11'd0;
            mon_cnt[d]  = 1;
            mon_gap[d]  = mon_idle[d];
         end else if (mon_idle[d] < 255) begin
            mon_idle[d]++;
         end
      end else begin
         mon_bits[d] = {mon_bits[d][9:0], s};
         mon_cnt[d]++;
         if (mon_cnt[d] == 11) begin
            mon_busy[d] = 1'b0;
            mon_idle[d] = 0;
            chk("pkt_expected", exp_q[d].size() > 0, 1'b1);
            if (exp_q[d].size() > 0) begin
               e = exp_q[d].pop_front();
               chk("pkt_bits", mon_bits[d], e.bits);
               if (e.gap != 8'hFF) chk("pkt_gap", mon_gap[d], e.gap);
               chk("done_at_stop", dn, mon_bits[d][9]);
               if (mon_bits[d][9]) last_ctl[d] = mon_bits[d][8:1];
               else                last_word[d] = {last_word[d][55:0], mon_bits[d][8:1]};
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            mon_busy[d] = 1'b0;
            mon_idle[d] = 255;
         end
      end else begin
         mon(0, bus0.sin, bus0.done);
         mon(1, bus1.sin, bus1.done);
      end
   end

   task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] n, input logic bad,
                       input bit hold, input logic [7:0] first_gap, output int k);
      exp_t        e;
      logic [63:0] w;
      logic [7:0]  by;
      logic [3:0]  crc;
      bit          ok;
      int          gp;
      gp = (d == 0) ? 0 : GAP1;
      if (d == 0) begin
         bus0.A = a; bus0.B = b; bus0.op = op; bus0.n_data = n; bus0.crc_bad = bad;
         bus0.start = 1'b1;
      end else begin
         bus1.A = a; bus1.B = b; bus1.op = op; bus1.n_data = n; bus1.crc_bad = bad;
         bus1.start = 1'b1;
      end
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if ((d == 0) ? bus0.ready : bus1.ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_ready", ok, 1'b1);
      @(posedge clk);
      #1;
      k = cyc;
      if (!hold) begin
         if (d == 0) bus0.start = 1'b0;
         else        bus1.start = 1'b0;
      end
      crc = crc_ref(a, b, op) ^ {4{bad}};
      for (int i = 0; i < int'(n); i++) begin
         if (i < 8) begin
            w  = {b, a} >> (56 - 8 * i);
            by = w[7:0];
         end else begin
            by = 8'h00;
         end
         e.bits = {1'b0, 1'b0, by, 1'b1};
         e.gap  = (i == 0) ? first_gap : 8'(gp);
         exp_q[d].push_back(e);
      end
      e.bits = {1'b0, 1'b1, 1'b0, op, crc, 1'b1};
      e.gap  = (n == 4'd0) ? first_gap : 8'(gp);
      exp_q[d].push_back(e);
   endtask

   task automatic wait_done(input int d, input int k, input int exp_len);
      bit ok;
      int t_done;
      ok     = 1'b0;
      t_done = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if ((d == 0) ? bus0.done : bus1.done) begin
            ok     = 1'b1;
            t_done = cyc;
            break;
         end
      end
      chk("done_seen", ok, 1'b1);
      if (ok) begin
         chk("frame_len", t_done - k + 1, exp_len);
         @(negedge clk);
         chk("done_width", (d == 0) ? bus0.done : bus1.done, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int kb;
      cyc = 0; vectors = 0; miscompares = 0;
      reset = 1'b1;
      bus0.start = 1'b0; bus0.A = '0; bus0.B = '0; bus0.op = '0; bus0.n_data = '0; bus0.crc_bad = 1'b0;
      bus1.start = 1'b0; bus1.A = '0; bus1.B = '0; bus1.op = '0; bus1.n_data = '0; bus1.crc_bad = 1'b0;
      last_word[0] = '0; last_word[1] = '0; last_ctl[0] = '0; last_ctl[1] = '0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_sin",   bus0.sin, 1'b1);
      chk("rst_ready", bus0.ready, 1'b1);
      chk("rst_done",  bus0.done, 1'b0);
      chk("rst_fcnt",  bus0.frame_cnt, 16'h0000);
      chk("rst_ready1", bus1.ready, 1'b1);
      chk("rst_sin1",  bus1.sin, 1'b1);

      // Abort inside data packet 3 while sin is low (B[6] = 0).
      send(0, 32'h12345678, 32'hA5A55A00, 3'b100, 4'd8, 1'b0, 1'b0, 8'hFF, k);
      repeat (36) @(posedge clk);
      #2;
      chk("mid_sin_before", bus0.sin, 1'b0);
      chk("mid_ready_busy", bus0.ready, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid_sin_async", bus0.sin, 1'b1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("mid_ready", bus0.ready, 1'b1);
      chk("mid_fcnt",  bus0.frame_cnt, 16'h0000);

      send(0, 32'h0, 32'h0, 3'b000, 4'd8, 1'b0, 1'b0, 8'hFF, k);
      wait_done(0, k, 99);
      chk("zero_ctl",  last_ctl[0], 8'h0B);
      chk("zero_fcnt", bus0.frame_cnt, 16'd1);

      send(0, 32'h00000001, 32'h00000002, 3'b100, 4'd8, 1'b0, 1'b0, 8'hFF, k);
      wait_done(0, k, 99);
      chk("nz_word",    last_word[0], 64'h00000002_00000001);
      chk("nz_ctl_hi",  last_ctl[0][7:4], 4'b0100);
      chk("nz_ctl_crc", last_ctl[0][3:0], crc_ref(32'h1, 32'h2, 3'b100));
      chk("nz_fcnt",    bus0.frame_cnt, 16'd2);

      send(0, 32'h0, 32'h0, 3'b000, 4'd8, 1'b1, 1'b0, 8'hFF, k);
      wait_done(0, k, 99);
      chk("bad_ctl", last_ctl[0], 8'h04);

      send(0, 32'h11111111, 32'h22222222, 3'b001, 4'd0, 1'b0, 1'b0, 8'hFF, k);
      wait_done(0, k, 11);
      chk("n0_ctl_op", last_ctl[0][6:4], 3'b001);

      send(0, 32'hDEADBEEF, 32'hCAFEBABE, 3'b101, 4'd3, 1'b0, 1'b0, 8'hFF, k);
      wait_done(0, k, 44);
      chk("n3_bytes", last_word[0][23:0], 24'hCAFEBA);

      send(0, 32'h89ABCDEF, 32'h01234567, 3'b110, 4'd10, 1'b0, 1'b0, 8'hFF, k);
      wait_done(0, k, 121);
      chk("n10_tail", last_word[0], 64'h456789AB_CDEF0000);
      chk("n10_fcnt", bus0.frame_cnt, 16'd6);

      // Gapped instance: single frame, then two frames with start held high.
      send(1, 32'hF0E1D2C3, 32'hB4A59687, 3'b101, 4'd8, 1'b0, 1'b0, 8'hFF, k);
      wait_done(1, k, 115);
      send(1, 32'h13579BDF, 32'h2468ACE0, 3'b000, 4'd8, 1'b0, 1'b1, 8'hFF, k);
      repeat (20) @(posedge clk);
      #1;
      chk("held_start_ready", bus1.ready, 1'b0);
      send(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 3'b100, 4'd5, 1'b1, 1'b0, 8'(IFG), kb);
      chk("b2b_spacing", kb - k, 115 + IFG);
      wait_done(1, kb, 76);
      chk("b2b_fcnt", bus1.frame_cnt, 16'd3);

      force dut1.r_frame_cnt = 16'hFFFF;
      @(posedge clk);
      #1 release dut1.r_frame_cnt;
      @(posedge clk);
      #1;
      chk("wrap_pre", bus1.frame_cnt, 16'hFFFF);
      send(1, 32'h0, 32'h1, 3'b001, 4'd0, 1'b0, 1'b0, 8'hFF, k);
      wait_done(1, k, 11);
      chk("wrap_fcnt", bus1.frame_cnt, 16'h0000);

      repeat (5) @(posedge clk);
      chk("q0_drained", exp_q[0].size(), 0);
      chk("q1_drained", exp_q[1].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
